// File: rtl/sram_tx_drain.sv
// sram_tx_drain: drains byte_count bytes from the byte SRAM (address 0 upward)
// and sends each one on tx_serial as an 8N1 frame (start 0, 8 data bits LSB
// first, stop 1). One SRAM read and one latch cycle precede each frame, which
// gives a 2-cycle idle-high gap between back-to-back frames.
module sram_tx_drain #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_W       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        byte_count,
  output logic              sram_re,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [7:0]        sram_data,
  output logic              tx_serial,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int IDX_W = ADDR_W + 1;  // must hold DEPTH itself so n=DEPTH terminates
  localparam int BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_START,
    S_DATA,
    S_STOP,
    S_FIN
  } state_t;

  state_t              state_reg, state_next;
  logic [BW-1:0]       baud_reg, baud_next;
  logic [2:0]          bit_reg, bit_next;
  logic [7:0]          shift_reg, shift_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [IDX_W-1:0]    n_reg, n_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic                tx_reg, tx_next;

  // State, counters, shift register and the registered serial output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      idx_reg   <= '0;
      n_reg     <= '0;
      addr_reg  <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      idx_reg   <= idx_next;
      n_reg     <= n_next;
      addr_reg  <= addr_next;
      tx_reg    <= tx_next;
    end
  end

  // Next-state logic; tx_next is derived from the state being entered so the
  // line changes exactly on the edge that enters START/DATA/STOP.
  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    idx_next   = idx_reg;
    n_next     = n_reg;
    addr_next  = addr_reg;
    tx_next    = 1'b1;

    case (state_reg)
      S_IDLE: begin
        if (start && (byte_count != 4'd0)) begin
          if (int'(byte_count) > DEPTH) n_next = IDX_W'(DEPTH);
          else                          n_next = IDX_W'(byte_count);
          idx_next   = '0;
          baud_next  = '0;
          bit_next   = '0;
          state_next = S_READ;
        end
      end
      S_READ: begin
        state_next = S_LATCH;
      end
      S_LATCH: begin
        // Read data is valid now, one cycle after the read enable.
        shift_next = sram_data;
        baud_next  = '0;
        state_next = S_START;
      end
      S_START: begin
        if (baud_reg == BAUD_LAST) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = S_DATA;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_reg == BAUD_LAST) begin
          baud_next  = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_reg == 3'd7) begin
            state_next = S_STOP;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_reg == BAUD_LAST) begin
          baud_next = '0;
          idx_next  = idx_reg + 1'b1;
          if (idx_next == n_reg) state_next = S_FIN;
          else                   state_next = S_READ;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end
      S_FIN: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Address is only reloaded when a read is about to happen; otherwise it holds.
    if (state_next == S_READ) begin
      addr_next = idx_next[ADDR_W-1:0];
    end

    case (state_next)
      S_START: tx_next = 1'b0;
      S_DATA:  tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign sram_re   = (state_reg == S_READ);
  assign sram_addr = addr_reg;
  assign tx_serial = tx_reg;
  assign busy      = (state_reg != S_IDLE);
  assign done      = (state_reg == S_FIN);

endmodule

// File: tb/tb_sram_tx_drain.sv
// tb_sram_tx_drain: checks sram_tx_drain (CLKS_PER_BIT=4) cycle by cycle
// against a waveform built from the frame rules: per byte a read cycle, a
// latch cycle, then start/8 data/stop bits of 4 cycles each, then one done cycle.
module tb_sram_tx_drain;

  localparam int CPB = 4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] byte_count;
  logic       sram_re;
  logic [2:0] sram_addr;
  logic [7:0] sram_data;
  logic       tx_serial;
  logic       busy;
  logic       done;

  logic [7:0] mem [8];

  int n_cmp = 0;
  int n_bad = 0;

  sram_tx_drain #(.CLKS_PER_BIT(CPB), .ADDR_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_count (byte_count),
    .sram_re    (sram_re),
    .sram_addr  (sram_addr),
    .sram_data  (sram_data),
    .tx_serial  (tx_serial),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM with registered read.
  initial sram_data = 8'h00;
  always @(posedge clk) if (sram_re) sram_data <= mem[sram_addr];

  typedef struct packed {
    logic       tx;
    logic       busy;
    logic       done;
    logic       re;
    logic [2:0] addr;
  } obs_t;

  obs_t exp_q[$];
  logic [2:0] prev_addr;

  typedef struct {
    logic [3:0] bc;
    int         exp_n;
    int         exp_busy;
    int         exp_done;
  } vec_t;

  vec_t vecs[6];

  function automatic obs_t mk(logic tx, logic b, logic d, logic re, logic [2:0] a);
    obs_t o;
    o.tx = tx; o.busy = b; o.done = d; o.re = re; o.addr = a;
    return o;
  endfunction

  // Expected per-cycle observation list, starting in the cycle after the accept edge.
  task automatic build_model(input int n);
    logic [7:0] b;
    exp_q = {};
    for (int j = 0; j < n; j++) begin
      b = mem[j];
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 3'(j)));
      exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 3'(j)));
      for (int c = 0; c < CPB; c++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 3'(j)));
      for (int k = 0; k < 8; k++)
        for (int c = 0; c < CPB; c++) exp_q.push_back(mk(b[k], 1'b1, 1'b0, 1'b0, 3'(j)));
      for (int c = 0; c < CPB; c++) exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 3'(j)));
    end
    if (n > 0) begin
      exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 3'(n - 1)));
      for (int c = 0; c < 3; c++) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'(n - 1)));
    end else begin
      for (int c = 0; c < 4; c++) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, prev_addr));
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  // Pulse start, then compare every cycle; optionally re-pulse start at cycle inject_cyc.
  task automatic run_drain(input logic [3:0] bc, input int n, input int inject_cyc,
                           output int busy_cnt, output int done_cnt);
    obs_t got;
    int   bad_here;
    build_model(n);
    busy_cnt = 0;
    done_cnt = 0;
    bad_here = 0;
    @(negedge clk);
    start = 1'b1;
    byte_count = bc;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      got = mk(tx_serial, busy, done, sram_re, sram_addr);
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      n_cmp++;
      if (got !== exp_q[k]) begin
        n_bad++;
        bad_here++;
        if (bad_here <= 40)
          $display("FAIL drain bc=%0d cyc%0d: got tx=%b busy=%b done=%b re=%b addr=%0d, required tx=%b busy=%b done=%b re=%b addr=%0d",
                   bc, k + 1, got.tx, got.busy, got.done, got.re, got.addr,
                   exp_q[k].tx, exp_q[k].busy, exp_q[k].done, exp_q[k].re, exp_q[k].addr);
      end
      // byte_count wanders after accept; it must have no effect.
      start = ((k + 1) == inject_cyc);
      byte_count = 4'($urandom);
    end
    start = 1'b0;
    if (n > 0) prev_addr = 3'(n - 1);
  endtask

  int bcnt, dcnt, rn;
  logic [3:0] rbc;

  initial begin
    vecs[0] = '{bc: 4'd1,  exp_n: 1, exp_busy: 43,  exp_done: 1};
    vecs[1] = '{bc: 4'd3,  exp_n: 3, exp_busy: 127, exp_done: 1};
    vecs[2] = '{bc: 4'd0,  exp_n: 0, exp_busy: 0,   exp_done: 0};
    vecs[3] = '{bc: 4'd12, exp_n: 8, exp_busy: 337, exp_done: 1};
    vecs[4] = '{bc: 4'd8,  exp_n: 8, exp_busy: 337, exp_done: 1};
    vecs[5] = '{bc: 4'd15, exp_n: 8, exp_busy: 337, exp_done: 1};

    for (int i = 0; i < 8; i++) mem[i] = 8'(8'h11 * (i + 1) ^ 8'h3C);
    prev_addr  = 3'd0;
    start      = 1'b0;
    byte_count = 4'd0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset tx", int'(tx_serial), 1);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset re", int'(sram_re), 0);
    check("reset addr", int'(sram_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven drains.
    for (int v = 0; v < 6; v++) begin
      if (v == 0) mem[0] = 8'hA5;
      if (v == 1) begin mem[0] = 8'h01; mem[1] = 8'h80; mem[2] = 8'hFF; end
      run_drain(vecs[v].bc, vecs[v].exp_n, 0, bcnt, dcnt);
      $display("vec %0d: bc=%0d busy_cycles=%0d done_pulses=%0d", v, vecs[v].bc, bcnt, dcnt);
      check($sformatf("vec%0d busy cycles", v), bcnt, vecs[v].exp_busy);
      check($sformatf("vec%0d done pulses", v), dcnt, vecs[v].exp_done);
    end

    // start re-pulsed during the 2nd frame of a 3-byte drain: ignored.
    mem[0] = 8'h5A; mem[1] = 8'hC3; mem[2] = 8'h0F;
    run_drain(4'd3, 3, 42 + 2 + 17, bcnt, dcnt);
    $display("start-while-busy: busy_cycles=%0d done_pulses=%0d", bcnt, dcnt);
    check("busy-start done pulses", dcnt, 1);
    check("busy-start busy cycles", bcnt, 127);

    // Reset for one cycle in the middle of DATA of the first frame.
    @(negedge clk);
    start = 1'b1;
    byte_count = 4'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2 + CPB + 9) @(negedge clk);
    check("pre-reset busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("async reset tx", int'(tx_serial), 1);
    check("async reset busy", int'(busy), 0);
    check("async reset addr", int'(sram_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 3 * CPB * 10; c++) begin
      @(negedge clk);
      dcnt += int'(done) + int'(busy) + int'(sram_re) + int'(!tx_serial);
    end
    $display("post-reset quiet window activity=%0d", dcnt);
    check("post-reset quiet", dcnt, 0);
    prev_addr = 3'd0;
    run_drain(4'd2, 2, 0, bcnt, dcnt);
    check("post-reset drain done", dcnt, 1);

    // Randomized drains against the model.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
      rbc = 4'($urandom_range(0, 15));
      rn  = (int'(rbc) > 8) ? 8 : int'(rbc);
      run_drain(rbc, rn, 0, bcnt, dcnt);
      $display("random %0d: bc=%0d busy_cycles=%0d done_pulses=%0d", r, rbc, bcnt, dcnt);
      check($sformatf("rand%0d done pulses", r), dcnt, (rn > 0) ? 1 : 0);
      check($sformatf("rand%0d busy cycles", r), bcnt, (rn > 0) ? rn * (2 + 10 * CPB) + 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
